// File: rtl/lfsr_gen.sv
// Parametrised LFSR with runtime Fibonacci/Galois selection, seed load,
// all-zero lock-up recovery, step counting and period-wrap detection.
module lfsr_gen #(
   parameter int unsigned      WIDTH    = 16,
   parameter logic [WIDTH-1:0] FIB_TAPS = 16'hB400,
   parameter logic [WIDTH-1:0] GAL_MASK = 16'h002D,
   parameter logic [WIDTH-1:0] SEED     = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             galois,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] state,
   output logic             bit_out,
   output logic [WIDTH-1:0] step_cnt,
   output logic             wrap,
   output logic             lockup
);

   // Control semantics: load and en are level requests sampled on each rising
   // edge, no handshake back. load beats lock-up recovery, which beats en;
   // with neither asserted every register holds and both pulses drop.

   logic [WIDTH-1:0] ref_seed;
   logic [WIDTH-1:0] fib_next;
   logic [WIDTH-1:0] gal_next;
   logic [WIDTH-1:0] step_next;
   logic             fib_fb;
   logic             is_zero;

   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      fib_fb    = ^(state & FIB_TAPS);
      fib_next  = {state[WIDTH-2:0], fib_fb};
      gal_next  = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GAL_MASK : '0);
      step_next = galois ? gal_next : fib_next;
      is_zero   = (state == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= SEED;
         ref_seed <= SEED;
         step_cnt <= '0;
         wrap     <= 1'b0;
         lockup   <= 1'b0;
      end else if (load) begin
         state    <= seed_in;
         ref_seed <= seed_in;
         step_cnt <= '0;
         wrap     <= 1'b0;
         lockup   <= 1'b0;
      end else if (en && is_zero) begin
         // An all-zero register never leaves zero; restart from the fixed seed.
         state    <= SEED;
         ref_seed <= SEED;
         step_cnt <= '0;
         wrap     <= 1'b0;
         lockup   <= 1'b1;
      end else if (en) begin
         state    <= step_next;
         step_cnt <= step_cnt + CNT_ONE;
         wrap     <= (step_next == ref_seed);
         lockup   <= 1'b0;
      end else begin
         wrap     <= 1'b0;
         lockup   <= 1'b0;
      end
   end

   assign bit_out = state[WIDTH-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: a 4-bit instance driven with hand-computed vectors through
// a scoreboard queue, plus a default 16-bit instance run over a full period.
module tb_lfsr_gen;

   localparam int EW = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en_a, gal_a, load_a;
   logic [3:0] seed_a;
   logic [3:0] state_a, cnt_a;
   logic       bit_a, wrap_a, lock_a;

   logic        en_b, gal_b, load_b;
   logic [15:0] seed_b;
   logic [15:0] state_b, cnt_b;
   logic        bit_b, wrap_b, lock_b;

   int total = 0;
   int bad   = 0;

   logic [EW-1:0] exp_q[$];
   string         tag_q[$];

   int          wrap_b_seen = 0;
   int          lock_b_seen = 0;
   logic [15:0] wrap_b_at   = '0;

   lfsr_gen #(
      .WIDTH(4), .FIB_TAPS(4'b1100), .GAL_MASK(4'b1001), .SEED(4'b1010)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .galois(gal_a), .load(load_a),
      .seed_in(seed_a), .state(state_a), .bit_out(bit_a), .step_cnt(cnt_a),
      .wrap(wrap_a), .lockup(lock_a)
   );

   lfsr_gen dut_b (
      .clk(clk), .rst(rst), .en(en_b), .galois(gal_b), .load(load_b),
      .seed_in(seed_b), .state(state_b), .bit_out(bit_b), .step_cnt(cnt_b),
      .wrap(wrap_b), .lockup(lock_b)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   // One clocked cycle of stimulus; the expected post-edge outputs go on the queue.
   task automatic drive(input logic e, input logic g, input logic l, input logic [3:0] sd,
                        input logic [3:0] es, input logic [3:0] ec, input logic ew,
                        input logic el, input string tag);
      @(negedge clk);
      en_a   = e;
      gal_a  = g;
      load_a = l;
      seed_a = sd;
      exp_q.push_back({es, ec, es[3], ew, el});
      tag_q.push_back(tag);
      @(posedge clk);
   endtask

   always @(posedge clk) begin : monitor_a
      logic [EW-1:0] e;
      string         t;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, 32'({state_a, cnt_a, bit_a, wrap_a, lock_a}), 32'(e));
      end
   end

   always @(posedge clk) begin : monitor_b
      #1;
      if (wrap_b) begin
         wrap_b_seen++;
         wrap_b_at = cnt_b;
      end
      if (lock_b) lock_b_seen++;
   end

   logic [3:0] fib_seq [16];
   logic [3:0] gal_seq [5];

   initial begin
      fib_seq = '{4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001,
                  4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101};
      gal_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b1011};

      rst = 1'b0;
      en_a = 1'b0; gal_a = 1'b0; load_a = 1'b0; seed_a = '0;
      en_b = 1'b0; gal_b = 1'b0; load_b = 1'b0; seed_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(state_a), 32'h0000_000A);
      check("rst_cnt", 32'(cnt_a), 32'h0);
      check("rst_pulses", 32'({wrap_a, lock_a}), 32'h0);
      check("rst_bit_out", 32'(bit_a), 32'h1);
      check("rst_state_b", 32'(state_b), 32'h0000_ACE1);
      @(negedge clk);
      rst = 1'b1;

      // Fibonacci full period: wrap pulses after step 15 with step_cnt 15.
      for (int i = 0; i < 16; i++)
         drive(1, 0, 0, 4'b0000, fib_seq[i], 4'((i + 1) % 16), (i == 14), 0,
               $sformatf("fib_step%0d", i + 1));
      drive(0, 0, 0, 4'b0000, 4'b0101, 4'd0, 0, 0, "hold");

      drive(0, 0, 1, 4'b0001, 4'b0001, 4'd0, 0, 0, "load_0001");
      for (int i = 0; i < 5; i++)
         drive(1, 1, 0, 4'b0000, gal_seq[i], 4'(i + 1), 0, 0,
               $sformatf("gal_step%0d", i + 1));
      drive(1, 0, 0, 4'b0000, 4'b0111, 4'd6, 0, 0, "mode_switch_fib");

      drive(1, 0, 1, 4'b0110, 4'b0110, 4'd0, 0, 0, "load_with_en");

      drive(0, 0, 1, 4'b0000, 4'b0000, 4'd0, 0, 0, "load_zero");
      drive(0, 0, 0, 4'b0000, 4'b0000, 4'd0, 0, 0, "zero_hold");
      drive(0, 0, 0, 4'b0000, 4'b0000, 4'd0, 0, 0, "zero_hold2");
      drive(1, 0, 0, 4'b0000, 4'b1010, 4'd0, 0, 1, "lockup_recover");
      drive(0, 0, 0, 4'b0000, 4'b1010, 4'd0, 0, 0, "lockup_one_cycle");
      drive(1, 0, 0, 4'b0000, 4'b0101, 4'd1, 0, 0, "after_recover1");
      drive(1, 0, 0, 4'b0000, 4'b1011, 4'd2, 0, 0, "after_recover2");
      drive(1, 0, 0, 4'b0000, 4'b0111, 4'd3, 0, 0, "after_recover3");

      // Asynchronous reset dropped between edges while en is still high.
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_state", 32'(state_a), 32'h0000_000A);
      check("async_rst_cnt", 32'(cnt_a), 32'h0);
      @(posedge clk);
      #1;
      check("rst_held_over_edge", 32'(state_a), 32'h0000_000A);
      @(negedge clk);
      en_a = 1'b0;
      #2 rst = 1'b1;
      drive(0, 0, 0, 4'b0000, 4'b1010, 4'd0, 0, 0, "release_en_low");
      drive(1, 0, 0, 4'b0000, 4'b0101, 4'd1, 0, 0, "resume");

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      // Default 16-bit instance: one full maximal-length period from SEED.
      wrap_b_seen = 0;
      lock_b_seen = 0;
      @(negedge clk);
      en_b = 1'b1;
      repeat (65535) @(posedge clk);
      @(negedge clk);
      en_b = 1'b0;
      check("w16_wrap_count", 32'(wrap_b_seen), 32'd1);
      check("w16_wrap_cnt", 32'(wrap_b_at), 32'd65535);
      check("w16_state", 32'(state_b), 32'h0000_ACE1);
      check("w16_no_lockup", 32'(lock_b_seen), 32'd0);
      @(posedge clk);
      #1;
      check("w16_wrap_drop", 32'(wrap_b), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
